// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side master for a synchronous FIFO with one-cycle read latency.
//   Words read from the FIFO land in a 2-entry elastic buffer and are
//   re-presented as a valid/ready stream. Under continuous m_ready the
//   reader sustains one beat per clock. Under backpressure the head word
//   and m_last are held stable. The stream is framed into bursts of
//   BURST_LEN beats, and m_last marks the final beat of each burst.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   en           read enable; when 0, no new FIFO reads are issued
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO read strobe (combinational)
//   fifo_rd_data FIFO read data, valid one cycle after an accepted read
//   m_data       stream data (head of buffer)
//   m_valid      stream data valid
//   m_ready      downstream ready
//   m_last       last beat of the current burst, qualified by m_valid
//   busy         buffer non-empty or a read in flight
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy
);

  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

  logic [1:0]            r_count;    // buffered words, 0..2
  logic                  r_pending;  // read accepted last cycle, data arrives now
  logic [DATA_WIDTH-1:0] r_head;     // oldest buffered word
  logic [DATA_WIDTH-1:0] r_tail;     // second word, valid when r_count == 2
  logic [15:0]           r_beat_cnt; // position of the head beat in its burst

  logic                  w_pop;
  logic [2:0]            w_occupancy;

  assign m_valid = (r_count != 2'd0);
  assign m_data  = r_head;
  assign m_last  = m_valid & (r_beat_cnt == LAST_BEAT);
  assign busy    = m_valid | r_pending;
  assign w_pop   = m_valid & m_ready;

  // Occupancy as it will stand after this cycle's push and pop. Subtracting
  // the pop lets a new read issue in the same cycle a word leaves, which is
  // what sustains one beat per clock. r_count >= w_pop, so no underflow.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
  assign fifo_rd_en  = !rst & en & !fifo_empty & (w_occupancy < 3'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 2'd0;
      r_pending  <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_beat_cnt <= 16'd0;
    end else begin
      // fifo_rd_en already includes !fifo_empty, so it marks an accepted read.
      r_pending <= fifo_rd_en;

      case ({r_pending, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head <= fifo_rd_data;
          end else begin
            r_tail <= fifo_rd_data;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count is unchanged. The incoming word goes behind any survivor.
          if (r_count == 2'd1) begin
            r_head <= fifo_rd_data;
          end else begin
            r_head <= r_tail;
            r_tail <= fifo_rd_data;
          end
        end
        default: begin
        end
      endcase

      if (w_pop) begin
        if (r_beat_cnt == LAST_BEAT) begin
          r_beat_cnt <= 16'd0;
        end else begin
          r_beat_cnt <= r_beat_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic          m_ready;
  logic [DW-1:0] fifo_rd_data;

  logic          rd_en16, m_valid16, m_last16, busy16;
  logic [DW-1:0] m_data16;
  logic          rd_en4, m_valid4, m_last4, busy4;
  logic [DW-1:0] m_data4;

  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en16), .fifo_rd_data(fifo_rd_data),
    .m_data(m_data16), .m_valid(m_valid16), .m_ready(m_ready),
    .m_last(m_last16), .busy(busy16)
  );

  // Second instance shares all inputs; only framing differs (BURST_LEN=4).
  fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd_en4), .fifo_rd_data(fifo_rd_data),
    .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
    .m_last(m_last4), .busy(busy4)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] fifo_q[$];  // contents of the modelled source FIFO
  logic [DW-1:0] exp_q[$];   // words expected on the stream, in order
  int bc16 = 0;
  int bc4 = 0;
  int n_pops = 0;
  int n_reads = 0;
  int n_last4 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int first, input int n, input bit rnd);
    logic [DW-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = rnd ? DW'($urandom_range(0, 255)) : DW'(first + i);
      fifo_q.push_back(w);
      exp_q.push_back(w);
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  // One clock: sample at negedge+1, model the FIFO read at posedge+1,
  // return at the next negedge.
  task automatic tick();
    logic          accept;
    logic [DW-1:0] e;
    #1;
    accept = rd_en16 & ~fifo_empty;
    if (rd_en16) n_reads++;
    if (m_valid16 && m_ready) begin
      check("pop_expected", 32'(exp_q.size() != 0), 1);
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
      check("data16", m_data16, e);
      check("data4", m_data4, e);
      check("valid4", m_valid4, 1);
      check("last16", m_last16, 32'(bc16 == 15));
      check("last4", m_last4, 32'(bc4 == 3));
      if (m_last4) n_last4++;
      bc16 = (bc16 + 1) % 16;
      bc4 = (bc4 + 1) % 4;
      n_pops++;
    end
    @(posedge clk);
    #1;
    if (accept) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    @(negedge clk);
  endtask

  // One reset cycle; source FIFO and expectations are discarded with it.
  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    bc16 = 0;
    bc4 = 0;
    fifo_empty = 1'b1;
  endtask

  int p0, r0, l0, k;

  initial begin
    rst = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    fifo_empty = 1'b1;
    fifo_rd_data = '0;
    @(negedge clk);

    // Reset held 3 cycles with a word available
    push_words(8'hA5, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_rd_en", rd_en16, 0);
      check("rst_valid", m_valid16, 0);
      check("rst_last", m_last16, 0);
      check("rst_busy", busy16, 0);
    end

    // Single word: read at t, valid at t+2 for one cycle
    rst = 1'b0;
    #1;
    check("single_rd_en_t", rd_en16, 1);
    tick();
    check("single_valid_t1", m_valid16, 0);
    check("single_busy_t1", busy16, 1);
    check("single_rd_en_t1", rd_en16, 0);
    tick();
    check("single_valid_t2", m_valid16, 1);
    check("single_data_t2", m_data16, 8'hA5);
    check("single_last_t2", m_last16, 0);
    tick();
    check("single_valid_t3", m_valid16, 0);
    check("single_busy_t3", busy16, 0);
    for (int i = 0; i < 3; i++) begin
      check("single_idle_rd_en", rd_en16, 0);
      tick();
    end

    // Full throughput: 0x00..0x1F, no bubbles, last on 0x0F and 0x1F
    pulse_reset();
    push_words(0, 32, 1'b0);
    k = 0;
    while (!m_valid16 && k < 5) begin
      tick();
      k++;
    end
    check("full_latency", k, 2);
    for (int i = 0; i < 32; i++) begin
      check("full_valid", m_valid16, 1);
      check("full_data", m_data16, i);
      check("full_last16", m_last16, 32'(i == 15 || i == 31));
      tick();
    end
    check("full_done", m_valid16, 0);

    // Backpressure: 10 words, m_ready low 8 cycles
    push_words(0, 10, 1'b0);
    m_ready = 1'b0;
    r0 = n_reads;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i >= 1) begin
        check("bp_valid", m_valid16, 1);
        check("bp_data", m_data16, 8'h00);
        check("bp_last", m_last16, 0);
        check("bp_rd_en", rd_en16, 0);
      end
    end
    check("bp_reads", n_reads - r0, 2);
    m_ready = 1'b1;
    p0 = n_pops;
    k = 0;
    while ((exp_q.size() != 0 || m_valid16) && k < 40) begin
      tick();
      k++;
    end
    check("bp_delivered", n_pops - p0, 10);
    check("bp_drained", exp_q.size(), 0);

    // Random stall, 200 words, BURST_LEN=4 framing on the second instance
    pulse_reset();
    push_words(0, 200, 1'b1);
    p0 = n_pops;
    l0 = n_last4;
    k = 0;
    while (exp_q.size() != 0 && k < 3000) begin
      m_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    m_ready = 1'b1;
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_pops", n_pops - p0, 200);
    check("rnd_last4_count", n_last4 - l0, 50);
    tick();
    tick();

    // en drop with one word buffered and one in flight
    pulse_reset();
    push_words(8'h20, 5, 1'b0);
    tick();
    tick();
    check("en_valid_t2", m_valid16, 1);
    check("en_busy_t2", busy16, 1);
    p0 = n_pops;
    en = 1'b0;
    #1;
    check("en_rd_en_off", rd_en16, 0);
    tick();
    check("en_valid_t3", m_valid16, 1);
    check("en_data_t3", m_data16, 8'h21);
    tick();
    check("en_valid_t4", m_valid16, 0);
    check("en_busy_t4", busy16, 0);
    for (int i = 0; i < 3; i++) begin
      check("en_idle_rd_en", rd_en16, 0);
      tick();
    end
    check("en_pops", n_pops - p0, 2);

    // Reset with two words buffered
    en = 1'b1;
    m_ready = 1'b0;
    tick();
    tick();
    tick();
    check("rst2_valid_before", m_valid16, 1);
    check("rst2_busy_before", busy16, 1);
    check("rst2_rd_en_full", rd_en16, 0);
    rst = 1'b1;
    tick();
    check("rst2_valid_after", m_valid16, 0);
    check("rst2_busy_after", busy16, 0);
    rst = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    bc16 = 0;
    bc4 = 0;
    fifo_empty = 1'b1;
    push_words(8'h40, 16, 1'b0);
    m_ready = 1'b1;
    k = 0;
    while (!m_valid16 && k < 5) begin
      tick();
      k++;
    end
    check("rst2_latency", k, 2);
    for (int i = 0; i < 16; i++) begin
      check("rst2_data", m_data16, 8'h40 + i);
      check("rst2_last16", m_last16, 32'(i == 15));
      tick();
    end
    check("rst2_done", m_valid16, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
